// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_feeder
// Brief    : Serialises handshaked parallel words onto a one-bit stream,
//            MSB/LSB first, with optional idle gap between words.
// Revision : 1.0 - initial release
// ============================================================================
module serial_bit_feeder #(
    parameter int   W          = 8,
    parameter bit   LSB_FIRST  = 1'b0,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] data_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         sout,
    output logic         bit_valid,
    output logic         word_done,
    output logic         busy
);

    localparam int              c_CW       = $clog2(W);
    localparam logic [c_CW-1:0] c_LAST     = c_CW'(W - 1);
    localparam logic [c_CW-1:0] c_PENULT   = c_CW'(W - 2);
    localparam logic [7:0]      c_GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam bit              c_NO_GAP   = (GAP_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_bit_cnt;
    logic [7:0]      r_gap_cnt;
    logic [W-1:0]    r_shreg;
    logic            r_sout;
    logic            r_bit_valid;
    logic            r_word_done;
    logic            r_busy;

    logic            w_last;
    logic            w_xfer;
    logic            w_first_bit;
    logic            w_next_bit;
    logic [W-1:0]    w_load_rest;
    logic [W-1:0]    w_shift_rest;

    assign w_last     = (r_state == S_SHIFT) && (r_bit_cnt == c_LAST);
    assign load_ready = reset && ((r_state == S_IDLE) || (w_last && c_NO_GAP));
    assign w_xfer     = load_valid && load_ready;

    // The shift register holds only the bits not yet driven on sout.
    assign w_first_bit  = LSB_FIRST ? data_in[0]   : data_in[W-1];
    assign w_load_rest  = LSB_FIRST ? (data_in >> 1) : (data_in << 1);
    assign w_next_bit   = LSB_FIRST ? r_shreg[0]   : r_shreg[W-1];
    assign w_shift_rest = LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_shreg     <= '0;
            r_sout      <= IDLE_LEVEL;
            r_bit_valid <= 1'b0;
            r_word_done <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_xfer) begin
            r_state     <= S_SHIFT;
            r_bit_cnt   <= '0;
            r_shreg     <= w_load_rest;
            r_sout      <= w_first_bit;
            r_bit_valid <= 1'b1;
            r_word_done <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (!w_last) begin
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        r_shreg     <= w_shift_rest;
                        r_sout      <= w_next_bit;
                        r_word_done <= (r_bit_cnt == c_PENULT);
                    end else if (!c_NO_GAP) begin
                        r_state     <= S_GAP;
                        r_gap_cnt   <= c_GAP_LOAD;
                        r_bit_cnt   <= '0;
                        r_sout      <= IDLE_LEVEL;
                        r_bit_valid <= 1'b0;
                        r_word_done <= 1'b0;
                    end else begin
                        r_state     <= S_IDLE;
                        r_bit_cnt   <= '0;
                        r_sout      <= IDLE_LEVEL;
                        r_bit_valid <= 1'b0;
                        r_word_done <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    r_sout      <= IDLE_LEVEL;
                    r_bit_valid <= 1'b0;
                    r_word_done <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_bit_cnt   <= '0;
                    r_gap_cnt   <= '0;
                    r_sout      <= IDLE_LEVEL;
                    r_bit_valid <= 1'b0;
                    r_word_done <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign sout      = r_sout;
    assign bit_valid = r_bit_valid;
    assign word_done = r_word_done;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_bit_feeder
// Brief    : Directed bench for serial_bit_feeder across three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_bit_feeder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // a: W=4 MSB-first no gap; b: W=4 gap 2 idle-high; c: W=8 LSB-first
    logic       lv_a = 1'b0, lv_b = 1'b0, lv_c = 1'b0;
    logic [3:0] d_a = '0, d_b = '0;
    logic [7:0] d_c = '0;
    logic lr_a, s_a, bv_a, wd_a, bz_a;
    logic lr_b, s_b, bv_b, wd_b, bz_b;
    logic lr_c, s_c, bv_c, wd_c, bz_c;

    serial_bit_feeder #(.W(4), .LSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .reset(rst_n), .data_in(d_a), .load_valid(lv_a), .load_ready(lr_a),
        .sout(s_a), .bit_valid(bv_a), .word_done(wd_a), .busy(bz_a));

    serial_bit_feeder #(.W(4), .LSB_FIRST(1'b0), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) u_b (
        .clk(clk), .reset(rst_n), .data_in(d_b), .load_valid(lv_b), .load_ready(lr_b),
        .sout(s_b), .bit_valid(bv_b), .word_done(wd_b), .busy(bz_b));

    serial_bit_feeder #(.W(8), .LSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_c (
        .clk(clk), .reset(rst_n), .data_in(d_c), .load_valid(lv_c), .load_ready(lr_c),
        .sout(s_c), .bit_valid(bv_c), .word_done(wd_c), .busy(bz_c));

    typedef struct {
        logic       rst;
        logic       lv;
        logic [3:0] d;
        logic       lr, s, bv, wd, bz;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk5(input string tag,
                        input logic lr, s, bv, wd, bz,
                        input logic elr, es, ebv, ewd, ebz);
        chk({tag, ".load_ready"}, lr, elr);
        chk({tag, ".sout"},       s,  es);
        chk({tag, ".bit_valid"},  bv, ebv);
        chk({tag, ".word_done"},  wd, ewd);
        chk({tag, ".busy"},       bz, ebz);
    endtask

    // Drive inputs for one cycle, check outputs mid-cycle, then cross the edge.
    task automatic cyc_b(input string tag, input logic lv, input logic [3:0] d,
                         input logic elr, es, ebv, ewd, ebz);
        lv_b = lv; d_b = d;
        #1;
        chk5(tag, lr_b, s_b, bv_b, wd_b, bz_b, elr, es, ebv, ewd, ebz);
        @(posedge clk); #1;
    endtask

    task automatic cyc_c(input string tag, input logic rst, input logic lv, input logic [7:0] d,
                         input logic elr, es, ebv, ewd, ebz);
        rst_n = rst; lv_c = lv; d_c = d;
        #1;
        chk5(tag, lr_c, s_c, bv_c, wd_c, bz_c, elr, es, ebv, ewd, ebz);
        @(posedge clk); #1;
    endtask

    logic [7:0] lsb_bits;
    logic [7:0] pat81;

    initial begin
        //           rst lv  d      lr s bv wd bz
        tbl[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        @(posedge clk); @(posedge clk); #1;

        // Instance a: single word, back-to-back words, capture at word_done edge
        for (int i = 0; i < 20; i++) begin
            rst_n = tbl[i].rst; lv_a = tbl[i].lv; d_a = tbl[i].d;
            #1;
            chk5($sformatf("a[%0d]", i), lr_a, s_a, bv_a, wd_a, bz_a,
                 tbl[i].lr, tbl[i].s, tbl[i].bv, tbl[i].wd, tbl[i].bz);
            @(posedge clk); #1;
        end
        lv_a = 1'b0;

        // Instance b: gap insertion, backpressure, idle level high
        cyc_b("b0",  1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_b("b1",  1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc_b("b2",  1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc_b("b3",  1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc_b("b4",  1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc_b("b5",  1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_b("b6",  1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_b("b7",  1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_b("b8",  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc_b("b9",  1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc_b("b10", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc_b("b11", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc_b("b12", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_b("b13", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc_b("b14", 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Instance c: LSB-first 8'h0D -> 1,0,1,1,0,0,0,0
        lsb_bits = 8'b1011_0000;
        cyc_c("c_ld0D", 1'b1, 1'b1, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc_c($sformatf("c_0D_bit%0d", i), 1'b1, 1'b0, 8'h00,
                  (i == 7), lsb_bits[7-i], 1'b1, (i == 7), 1'b1);
        end

        // Mid-word reset on 8'hFF, then 8'h81 must shift cleanly
        cyc_c("c_ldFF",  1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc_c("c_FF_b0", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc_c("c_FF_b1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc_c("c_rst",   1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc_c("c_ld81",  1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pat81 = 8'b1000_0001;
        for (int i = 0; i < 8; i++) begin
            cyc_c($sformatf("c_81_bit%0d", i), 1'b1, 1'b0, 8'h00,
                  (i == 7), pat81[7-i], 1'b1, (i == 7), 1'b1);
        end
        cyc_c("c_idle", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
